// File: rtl/skolem_exhaustive_checker.sv
// Exhaustive Skolem witness checker: sweeps every universal input vector,
// probes the spec evaluator with both candidate values of the existential
// bit, and counts vectors where the Skolem output is not a valid witness.
module skolem_exhaustive_checker #(
  parameter int N_IN   = 7,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec_out,
  output logic            cand_out,
  input  logic            sk_in,
  input  logic            spec_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   fail_count,
  output logic [N_IN:0]   nowit_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  typedef enum logic [2:0] {IDLE, EVAL0, EVAL1, CHECK, FIN} state_e;

  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN:0]   CNT_ONE  = {{N_IN{1'b0}}, 1'b1};
  localparam logic [N_IN:0]   CNT_MAX  = {1'b1, {N_IN{1'b0}}};
  localparam logic [3:0]      SETTLE_L = 4'(SETTLE);

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            cand_q, cand_d;
  logic [3:0]      settle_q, settle_d;
  logic            sk_q, sk_d;
  logic            s0_q, s0_d;
  logic            s1_q, s1_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [N_IN:0]   fail_q, fail_d;
  logic [N_IN:0]   nowit_q, nowit_d;
  logic [N_IN-1:0] ffv_q, ffv_d;
  logic            ffvalid_q, ffvalid_d;

  logic skOk, anyOk;

  // The Skolem output is a witness when the spec holds for the candidate it picked
  assign skOk  = sk_q ? s1_q : s0_q;
  assign anyOk = s0_q | s1_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      cand_q    <= 1'b0;
      settle_q  <= '0;
      sk_q      <= 1'b0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= '0;
      nowit_q   <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cand_q    <= cand_d;
      settle_q  <= settle_d;
      sk_q      <= sk_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      nowit_q   <= nowit_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
    end
  end

  // Next-state logic: sweep sequencing, sampling at the end of each settle window, tallying
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cand_d    = cand_q;
    settle_d  = settle_q;
    sk_d      = sk_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    busy_d    = busy_q;
    done_d    = done_q;
    fail_d    = fail_q;
    nowit_d   = nowit_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            fail_d    = '0;
            nowit_d   = '0;
            ffv_d     = '0;
            ffvalid_d = 1'b0;
            done_d    = 1'b0;
            vec_d     = '0;
            cand_d    = 1'b0;
            settle_d  = '0;
            busy_d    = 1'b1;
            state_d   = EVAL0;
          end
        end
        EVAL0: begin
          if (settle_q == SETTLE_L) begin
            sk_d     = sk_in;
            s0_d     = spec_in;
            cand_d   = 1'b1;
            settle_d = '0;
            state_d  = EVAL1;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
        EVAL1: begin
          if (settle_q == SETTLE_L) begin
            s1_d     = spec_in;
            settle_d = '0;
            state_d  = CHECK;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
        CHECK: begin
          if (!anyOk) begin
            if (nowit_q != CNT_MAX) nowit_d = nowit_q + CNT_ONE;
          end else if (!skOk) begin
            if (fail_q != CNT_MAX) fail_d = fail_q + CNT_ONE;
            if (!ffvalid_q) begin
              ffv_d     = vec_q;
              ffvalid_d = 1'b1;
            end
          end
          if (vec_q == VEC_LAST) begin
            state_d = FIN;
          end else begin
            vec_d   = vec_q + VEC_ONE;
            cand_d  = 1'b0;
            state_d = EVAL0;
          end
        end
        FIN: begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign vec_out          = vec_q;
  assign cand_out         = cand_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = done_q && (fail_q == '0);
  assign fail_count       = fail_q;
  assign nowit_count      = nowit_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_skolem_exhaustive_checker.sv
// Bench for skolem_exhaustive_checker: two instances (SETTLE=1 and SETTLE=0)
// run in lock-step against table-driven Skolem/spec environments.
module tb_skolem_exhaustive_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic [6:0] vecA [2];
  logic       candA [2];
  logic       skA [2];
  logic       specA [2];
  logic       busyA [2];
  logic       doneA [2];
  logic       passA [2];
  logic [7:0] failA [2];
  logic [7:0] nowitA [2];
  logic [6:0] ffvA [2];
  logic       ffvalA [2];

  // Environment tables: Skolem output per vector, and which candidates satisfy the spec
  logic       skTab [128];
  logic [1:0] specTab [128];

  logic [7:0] prevKey = '0;
  logic       gSk = 1'b0;
  logic       gSpec = 1'b0;
  logic       settled;

  int checks = 0;
  int errors = 0;
  int lat [2];
  int expLat [2];

  always #5 clk = ~clk;

  skolem_exhaustive_checker #(.N_IN(7), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .vec_out(vecA[0]), .cand_out(candA[0]), .sk_in(skA[0]), .spec_in(specA[0]),
    .busy(busyA[0]), .done(doneA[0]), .pass(passA[0]),
    .fail_count(failA[0]), .nowit_count(nowitA[0]),
    .first_fail_vec(ffvA[0]), .first_fail_valid(ffvalA[0])
  );

  skolem_exhaustive_checker #(.N_IN(7), .SETTLE(0)) dut_s0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .vec_out(vecA[1]), .cand_out(candA[1]), .sk_in(skA[1]), .spec_in(specA[1]),
    .busy(busyA[1]), .done(doneA[1]), .pass(passA[1]),
    .fail_count(failA[1]), .nowit_count(nowitA[1]),
    .first_fail_vec(ffvA[1]), .first_fail_valid(ffvalA[1])
  );

  // Tracks the last driven vector/candidate and produces garbage for unsettled cycles
  always_ff @(posedge clk) begin
    prevKey <= {vecA[0], candA[0]};
    gSk     <= 1'($urandom);
    gSpec   <= 1'($urandom);
  end

  // Combinational environments; the SETTLE=1 instance sees garbage until inputs have been stable one cycle
  always_comb begin
    settled  = ({vecA[0], candA[0]} == prevKey);
    skA[0]   = settled ? skTab[vecA[0]] : gSk;
    specA[0] = settled ? specTab[vecA[0]][candA[0]] : gSpec;
    skA[1]   = skTab[vecA[1]];
    specA[1] = specTab[vecA[1]][candA[1]];
  end

  task automatic set_correct();
    for (int v = 0; v < 128; v++) begin
      logic [6:0] vv;
      vv = 7'(v);
      skTab[v]   = ^vv;
      specTab[v] = (^vv) ? 2'b10 : 2'b01;
    end
  endtask

  task automatic run_sweep(input bit doStart, input int pulseAt, input int stopAt);
    int cyc;
    lat[0] = -1;
    lat[1] = -1;
    if (doStart) begin
      @(negedge clk); start = 1'b1;
      @(posedge clk);
    end
    cyc = 0;
    while ((lat[0] < 0 || lat[1] < 0) && cyc < 1000 && cyc != stopAt) begin
      @(negedge clk); start = (cyc == pulseAt);
      @(posedge clk); cyc++;
      #1;
      for (int d = 0; d < 2; d++) if (lat[d] < 0 && doneA[d]) lat[d] = cyc;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({vecA[d], candA[d], busyA[d], doneA[d], passA[d], failA[d], nowitA[d], ffvA[d], ffvalA[d]} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs dut%0d got vec=%h busy=%b done=%b fail=%0d nowit=%0d ffv=%h want all zero",
                 d, vecA[d], busyA[d], doneA[d], failA[d], nowitA[d], ffvA[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_correct();
    set_correct();
    run_sweep(1'b1, 100, -1);
    for (int d = 0; d < 2; d++) begin
      checks++; if (lat[d] !== expLat[d]) begin errors++; $display("[TB] FAIL correct.latency dut%0d got %0d want %0d", d, lat[d], expLat[d]); end
      checks++; if (failA[d] !== 8'd0) begin errors++; $display("[TB] FAIL correct.fail_count dut%0d got %0d want 0", d, failA[d]); end
      checks++; if (nowitA[d] !== 8'd0) begin errors++; $display("[TB] FAIL correct.nowit_count dut%0d got %0d want 0", d, nowitA[d]); end
      checks++; if (passA[d] !== 1'b1) begin errors++; $display("[TB] FAIL correct.pass dut%0d got %b want 1", d, passA[d]); end
      checks++; if (busyA[d] !== 1'b0) begin errors++; $display("[TB] FAIL correct.busy dut%0d got %b want 0", d, busyA[d]); end
    end
  endtask

  task automatic test_no_witness();
    for (int v = 0; v < 128; v++) begin
      skTab[v]   = 1'($urandom);
      specTab[v] = 2'b00;
    end
    run_sweep(1'b1, -1, -1);
    for (int d = 0; d < 2; d++) begin
      checks++; if (lat[d] !== expLat[d]) begin errors++; $display("[TB] FAIL nowit.latency dut%0d got %0d want %0d", d, lat[d], expLat[d]); end
      checks++; if (nowitA[d] !== 8'd128) begin errors++; $display("[TB] FAIL nowit.nowit_count dut%0d got %0d want 128", d, nowitA[d]); end
      checks++; if (failA[d] !== 8'd0) begin errors++; $display("[TB] FAIL nowit.fail_count dut%0d got %0d want 0", d, failA[d]); end
      checks++; if (passA[d] !== 1'b1) begin errors++; $display("[TB] FAIL nowit.pass dut%0d got %b want 1", d, passA[d]); end
      checks++; if (ffvalA[d] !== 1'b0) begin errors++; $display("[TB] FAIL nowit.first_fail_valid dut%0d got %b want 0", d, ffvalA[d]); end
    end
  endtask

  task automatic test_broken();
    for (int v = 0; v < 128; v++) begin
      skTab[v]   = 1'b0;
      specTab[v] = 2'b10;
    end
    run_sweep(1'b1, -1, -1);
    for (int d = 0; d < 2; d++) begin
      checks++; if (failA[d] !== 8'd128) begin errors++; $display("[TB] FAIL broken.fail_count dut%0d got %0d want 128", d, failA[d]); end
      checks++; if (nowitA[d] !== 8'd0) begin errors++; $display("[TB] FAIL broken.nowit_count dut%0d got %0d want 0", d, nowitA[d]); end
      checks++; if (ffvA[d] !== 7'h00 || ffvalA[d] !== 1'b1) begin errors++; $display("[TB] FAIL broken.first_fail dut%0d got vec=%h valid=%b want vec=00 valid=1", d, ffvA[d], ffvalA[d]); end
      checks++; if (passA[d] !== 1'b0 || doneA[d] !== 1'b1) begin errors++; $display("[TB] FAIL broken.pass_done dut%0d got pass=%b done=%b want pass=0 done=1", d, passA[d], doneA[d]); end
    end
  endtask

  task automatic test_single_fault();
    set_correct();
    skTab[7'h35] = ~skTab[7'h35];
    skTab[7'h50] = ~skTab[7'h50];
    run_sweep(1'b1, -1, -1);
    for (int d = 0; d < 2; d++) begin
      checks++; if (failA[d] !== 8'd2) begin errors++; $display("[TB] FAIL single.fail_count dut%0d got %0d want 2", d, failA[d]); end
      checks++; if (ffvA[d] !== 7'h35 || ffvalA[d] !== 1'b1) begin errors++; $display("[TB] FAIL single.first_fail dut%0d got vec=%h valid=%b want vec=35 valid=1", d, ffvA[d], ffvalA[d]); end
      checks++; if (passA[d] !== 1'b0) begin errors++; $display("[TB] FAIL single.pass dut%0d got %b want 0", d, passA[d]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      int eFail, eNowit;
      logic [6:0] eFfv;
      logic eFfValid;
      for (int v = 0; v < 128; v++) begin
        skTab[v]   = 1'($urandom);
        specTab[v] = 2'($urandom);
      end
      eFail = 0; eNowit = 0; eFfv = '0; eFfValid = 1'b0;
      for (int v = 0; v < 128; v++) begin
        if (specTab[v] == 2'b00) eNowit++;
        else if (!specTab[v][skTab[v]]) begin
          eFail++;
          if (!eFfValid) begin eFfv = 7'(v); eFfValid = 1'b1; end
        end
      end
      run_sweep(1'b1, -1, -1);
      for (int d = 0; d < 2; d++) begin
        checks++; if (lat[d] !== expLat[d]) begin errors++; $display("[TB] FAIL random%0d.latency dut%0d got %0d want %0d", it, d, lat[d], expLat[d]); end
        checks++; if (int'(failA[d]) !== eFail) begin errors++; $display("[TB] FAIL random%0d.fail_count dut%0d got %0d want %0d", it, d, failA[d], eFail); end
        checks++; if (int'(nowitA[d]) !== eNowit) begin errors++; $display("[TB] FAIL random%0d.nowit_count dut%0d got %0d want %0d", it, d, nowitA[d], eNowit); end
        checks++; if (ffvA[d] !== eFfv || ffvalA[d] !== eFfValid) begin errors++; $display("[TB] FAIL random%0d.first_fail dut%0d got vec=%h valid=%b want vec=%h valid=%b", it, d, ffvA[d], ffvalA[d], eFfv, eFfValid); end
        checks++; if (passA[d] !== (eFail == 0)) begin errors++; $display("[TB] FAIL random%0d.pass dut%0d got %b want %b", it, d, passA[d], (eFail == 0)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (doneA[d] !== 1'b1 || busyA[d] !== 1'b0) begin errors++; $display("[TB] FAIL idle_abort dut%0d got done=%b busy=%b want done=1 busy=0", d, doneA[d], busyA[d]); end
    end
    @(negedge clk); abort = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (doneA[d] !== 1'b0 || busyA[d] !== 1'b1) begin errors++; $display("[TB] FAIL restart dut%0d got done=%b busy=%b want done=0 busy=1", d, doneA[d], busyA[d]); end
    end
    set_correct();
    run_sweep(1'b0, -1, -1);
    for (int d = 0; d < 2; d++) begin
      checks++; if (lat[d] !== expLat[d] || passA[d] !== 1'b1) begin errors++; $display("[TB] FAIL back_to_back dut%0d got lat=%0d pass=%b want lat=%0d pass=1", d, lat[d], passA[d], expLat[d]); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    set_correct();
    run_sweep(1'b1, -1, 300);
    @(negedge clk); rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({vecA[d], candA[d], busyA[d], doneA[d], passA[d], failA[d], nowitA[d], ffvA[d], ffvalA[d]} !== '0) begin
        errors++;
        $display("[TB] FAIL midreset_outputs dut%0d got vec=%h busy=%b done=%b fail=%0d nowit=%0d want all zero",
                 d, vecA[d], busyA[d], doneA[d], failA[d], nowitA[d]);
      end
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (busyA[d] !== 1'b0) begin errors++; $display("[TB] FAIL midreset_idle dut%0d got busy=%b want 0", d, busyA[d]); end
    end
  endtask

  task automatic test_abort();
    set_correct();
    run_sweep(1'b1, -1, 50);
    for (int d = 0; d < 2; d++) begin
      checks++; if (busyA[d] !== 1'b1) begin errors++; $display("[TB] FAIL abort.busy_before dut%0d got %b want 1", d, busyA[d]); end
    end
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (busyA[d] !== 1'b0 || doneA[d] !== 1'b0) begin errors++; $display("[TB] FAIL abort.after dut%0d got busy=%b done=%b want busy=0 done=0", d, busyA[d], doneA[d]); end
    end
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (busyA[d] !== 1'b0) begin errors++; $display("[TB] FAIL abort.wins_over_start dut%0d got busy=%b want 0", d, busyA[d]); end
    end
    @(negedge clk); start = 1'b0; abort = 1'b0;
    run_sweep(1'b1, -1, -1);
    for (int d = 0; d < 2; d++) begin
      checks++; if (lat[d] !== expLat[d] || passA[d] !== 1'b1 || failA[d] !== 8'd0) begin errors++; $display("[TB] FAIL abort.clean_sweep dut%0d got lat=%0d pass=%b fail=%0d want lat=%0d pass=1 fail=0", d, lat[d], passA[d], failA[d], expLat[d]); end
    end
  endtask

  // Scenario sequence
  initial begin
    expLat[0] = 128 * (2 * 1 + 3) + 1;
    expLat[1] = 128 * (2 * 0 + 3) + 1;
    set_correct();
    test_reset();
    test_correct();
    test_no_witness();
    test_broken();
    test_single_fault();
    test_random();
    test_back_to_back();
    test_reset_mid_sweep();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
